// File: rtl/comms_pkg.sv
// Shared state encodings and default geometry for the serial link.
package comms_pkg;

    localparam int DEF_DATA_W   = 256;
    localparam int DEF_DIV_LOG2 = 3;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_DONE = 2'd2
    } tx_state_t;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_RECV = 1'b1
    } rx_state_t;

endpackage

// File: rtl/comms_sync.sv
// Two-flop synchroniser for one asynchronous input line.
module comms_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[0], i_d};
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/comms_link.sv
// Bidirectional framed serial link: TX serialiser with clock divider, RX deserialiser
// sampling the remote lines through synchronisers. Everything runs on clk.
module comms_link
    import comms_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DIV_LOG2 = DEF_DIV_LOG2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              startTransfer,
    input  logic              readyForSend,
    input  logic [DATA_W-1:0] sendBuffer,
    output logic              txBusy,
    output logic              txDone,
    output logic              clkOut,
    output logic              dataOut,
    output logic              frameOut,
    input  logic              clkIn,
    input  logic              dataIn,
    input  logic              frameIn,
    output logic [DATA_W-1:0] receiveBuffer,
    output logic              rxValid,
    output logic              rxError,
    output logic              readyForReceive
);

    // The RX counter must hold one count past DATA_W to remember overflow.
    localparam int CNT_W = $clog2(DATA_W + 2);
    localparam int IDX_W = $clog2(DATA_W);

    tx_state_t           r_tx_state, w_tx_state_nx;
    logic [DATA_W-1:0]   r_shadow, w_shadow_nx;
    logic [CNT_W-1:0]    r_bit_idx, w_bit_idx_nx;
    logic [DIV_LOG2-1:0] r_cdiv, w_cdiv_nx;
    logic r_clk_out, w_clk_out_nx, r_data_out, w_data_out_nx;
    logic r_frame_out, w_frame_out_nx, r_tx_busy, w_tx_busy_nx, r_tx_done, w_tx_done_nx;

    always_comb begin
        w_tx_state_nx  = r_tx_state;
        w_shadow_nx    = r_shadow;
        w_bit_idx_nx   = r_bit_idx;
        w_cdiv_nx      = r_cdiv;
        w_clk_out_nx   = r_clk_out;
        w_data_out_nx  = r_data_out;
        w_frame_out_nx = r_frame_out;
        w_tx_busy_nx   = r_tx_busy;
        w_tx_done_nx   = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (startTransfer && readyForSend) begin
                    w_tx_state_nx  = TX_SEND;
                    w_shadow_nx    = sendBuffer;
                    w_bit_idx_nx   = '0;
                    w_cdiv_nx      = '0;
                    w_clk_out_nx   = 1'b0;
                    w_data_out_nx  = sendBuffer[0];
                    w_frame_out_nx = 1'b1;
                    w_tx_busy_nx   = 1'b1;
                end
            end
            TX_SEND: begin
                // clkOut follows the divider MSB it is registered with, so the
                // next data bit and the clkOut fall appear on the same edge.
                w_cdiv_nx    = r_cdiv + 1'b1;
                w_clk_out_nx = w_cdiv_nx[DIV_LOG2-1];
                if (&r_cdiv) begin
                    if (r_bit_idx == CNT_W'(DATA_W - 1)) begin
                        w_tx_state_nx  = TX_DONE;
                        w_clk_out_nx   = 1'b0;
                        w_data_out_nx  = 1'b0;
                        w_frame_out_nx = 1'b0;
                        w_tx_busy_nx   = 1'b0;
                        w_tx_done_nx   = 1'b1;
                    end else begin
                        w_bit_idx_nx  = r_bit_idx + 1'b1;
                        w_shadow_nx   = r_shadow >> 1;
                        w_data_out_nx = r_shadow[1];
                    end
                end
            end
            TX_DONE: w_tx_state_nx = TX_IDLE;
            default: w_tx_state_nx = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state  <= TX_IDLE;
            r_shadow    <= '0;
            r_bit_idx   <= '0;
            r_cdiv      <= '0;
            r_clk_out   <= 1'b0;
            r_data_out  <= 1'b0;
            r_frame_out <= 1'b0;
            r_tx_busy   <= 1'b0;
            r_tx_done   <= 1'b0;
        end else begin
            r_tx_state  <= w_tx_state_nx;
            r_shadow    <= w_shadow_nx;
            r_bit_idx   <= w_bit_idx_nx;
            r_cdiv      <= w_cdiv_nx;
            r_clk_out   <= w_clk_out_nx;
            r_data_out  <= w_data_out_nx;
            r_frame_out <= w_frame_out_nx;
            r_tx_busy   <= w_tx_busy_nx;
            r_tx_done   <= w_tx_done_nx;
        end
    end

    logic w_clk_s, w_data_s, w_frame_s;

    comms_sync u_sync_clk   (.clk(clk), .rst(rst), .i_d(clkIn),   .o_q(w_clk_s));
    comms_sync u_sync_data  (.clk(clk), .rst(rst), .i_d(dataIn),  .o_q(w_data_s));
    comms_sync u_sync_frame (.clk(clk), .rst(rst), .i_d(frameIn), .o_q(w_frame_s));

    rx_state_t         r_rx_state, w_rx_state_nx;
    logic              r_clk_d, r_frame_d;
    logic [CNT_W-1:0]  r_rx_cnt, w_rx_cnt_nx;
    logic [DATA_W-1:0] r_rx_shift, w_rx_shift_nx, r_rx_buf, w_rx_buf_nx;
    logic r_rx_valid, w_rx_valid_nx, r_rx_error, w_rx_error_nx, r_rx_ready, w_rx_ready_nx;
    logic w_clk_rise, w_frame_rise, w_frame_fall;

    assign w_clk_rise   = w_clk_s & ~r_clk_d;
    assign w_frame_rise = w_frame_s & ~r_frame_d;
    assign w_frame_fall = ~w_frame_s & r_frame_d;

    always_comb begin
        w_rx_state_nx = r_rx_state;
        w_rx_cnt_nx   = r_rx_cnt;
        w_rx_shift_nx = r_rx_shift;
        w_rx_buf_nx   = r_rx_buf;
        w_rx_valid_nx = 1'b0;
        w_rx_error_nx = 1'b0;
        w_rx_ready_nx = r_rx_ready;
        case (r_rx_state)
            RX_IDLE: begin
                if (w_frame_rise) begin
                    w_rx_state_nx = RX_RECV;
                    w_rx_cnt_nx   = '0;
                    w_rx_ready_nx = 1'b0;
                end
            end
            RX_RECV: begin
                // A clock edge landing with the frame fall still counts toward the length.
                if (w_clk_rise) begin
                    if (r_rx_cnt < CNT_W'(DATA_W))
                        w_rx_shift_nx[r_rx_cnt[IDX_W-1:0]] = w_data_s;
                    if (r_rx_cnt <= CNT_W'(DATA_W))
                        w_rx_cnt_nx = r_rx_cnt + 1'b1;
                end
                if (w_frame_fall) begin
                    w_rx_state_nx = RX_IDLE;
                    w_rx_ready_nx = 1'b1;
                    if (w_rx_cnt_nx == CNT_W'(DATA_W)) begin
                        w_rx_buf_nx   = w_rx_shift_nx;
                        w_rx_valid_nx = 1'b1;
                    end else begin
                        w_rx_error_nx = 1'b1;
                    end
                end
            end
            default: w_rx_state_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state <= RX_IDLE;
            r_clk_d    <= 1'b0;
            r_frame_d  <= 1'b0;
            r_rx_cnt   <= '0;
            r_rx_shift <= '0;
            r_rx_buf   <= '0;
            r_rx_valid <= 1'b0;
            r_rx_error <= 1'b0;
            r_rx_ready <= 1'b1;
        end else begin
            r_rx_state <= w_rx_state_nx;
            r_clk_d    <= w_clk_s;
            r_frame_d  <= w_frame_s;
            r_rx_cnt   <= w_rx_cnt_nx;
            r_rx_shift <= w_rx_shift_nx;
            r_rx_buf   <= w_rx_buf_nx;
            r_rx_valid <= w_rx_valid_nx;
            r_rx_error <= w_rx_error_nx;
            r_rx_ready <= w_rx_ready_nx;
        end
    end

    assign txBusy          = r_tx_busy;
    assign txDone          = r_tx_done;
    assign clkOut          = r_clk_out;
    assign dataOut         = r_data_out;
    assign frameOut        = r_frame_out;
    assign receiveBuffer   = r_rx_buf;
    assign rxValid         = r_rx_valid;
    assign rxError         = r_rx_error;
    assign readyForReceive = r_rx_ready;

endmodule

// File: tb/tb_comms_link.sv
// Directed bench: link A in loopback (or driven directly), B listening to A, C small-geometry loopback.
module tb_comms_link;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;

    logic         a_start, a_ready;
    logic [255:0] a_send, a_rbuf;
    logic a_busy, a_done, a_clko, a_datao, a_frameo, a_rxv, a_rxe, a_rdy;
    logic sel_direct, d_clk, d_data, d_frame;
    logic a_clki, a_datai, a_framei;

    assign a_clki   = sel_direct ? d_clk   : a_clko;
    assign a_datai  = sel_direct ? d_data  : a_datao;
    assign a_framei = sel_direct ? d_frame : a_frameo;

    logic [255:0] b_rbuf;
    logic b_busy, b_done, b_clko, b_datao, b_frameo, b_rxv, b_rxe, b_rdy;

    logic       c_start;
    logic [7:0] c_send, c_rbuf;
    logic c_busy, c_done, c_clko, c_datao, c_frameo, c_rxv, c_rxe, c_rdy;

    comms_link #(.DATA_W(256), .DIV_LOG2(3)) u_a (
        .clk(clk), .rst(rst_a), .startTransfer(a_start), .readyForSend(a_ready),
        .sendBuffer(a_send), .txBusy(a_busy), .txDone(a_done), .clkOut(a_clko),
        .dataOut(a_datao), .frameOut(a_frameo), .clkIn(a_clki), .dataIn(a_datai),
        .frameIn(a_framei), .receiveBuffer(a_rbuf), .rxValid(a_rxv), .rxError(a_rxe),
        .readyForReceive(a_rdy));

    comms_link #(.DATA_W(256), .DIV_LOG2(3)) u_b (
        .clk(clk), .rst(rst_b), .startTransfer(1'b0), .readyForSend(1'b0),
        .sendBuffer('0), .txBusy(b_busy), .txDone(b_done), .clkOut(b_clko),
        .dataOut(b_datao), .frameOut(b_frameo), .clkIn(a_clko), .dataIn(a_datao),
        .frameIn(a_frameo), .receiveBuffer(b_rbuf), .rxValid(b_rxv), .rxError(b_rxe),
        .readyForReceive(b_rdy));

    comms_link #(.DATA_W(8), .DIV_LOG2(2)) u_c (
        .clk(clk), .rst(rst_b), .startTransfer(c_start), .readyForSend(1'b1),
        .sendBuffer(c_send), .txBusy(c_busy), .txDone(c_done), .clkOut(c_clko),
        .dataOut(c_datao), .frameOut(c_frameo), .clkIn(c_clko), .dataIn(c_datao),
        .frameIn(c_frameo), .receiveBuffer(c_rbuf), .rxValid(c_rxv), .rxError(c_rxe),
        .readyForReceive(c_rdy));

    int   cyc = 0, a_nv = 0, a_ne = 0, b_nv = 0, b_ne = 0, c_nv = 0, c_ne = 0, c_rise = 0;
    logic c_prev = 1'b0;

    always @(negedge clk) begin
        cyc    <= cyc + 1;
        a_nv   <= a_nv + int'(a_rxv);
        a_ne   <= a_ne + int'(a_rxe);
        b_nv   <= b_nv + int'(b_rxv);
        b_ne   <= b_ne + int'(b_rxe);
        c_nv   <= c_nv + int'(c_rxv);
        c_ne   <= c_ne + int'(c_rxe);
        c_prev <= c_clko;
        if (c_clko && !c_prev) c_rise <= c_rise + 1;
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input bit use_c);
        int k = 0;
        while (k < 3000) begin
            @(negedge clk);
            k++;
            if (use_c ? c_done : a_done) break;
        end
    endtask

    task automatic drive_frame(input int n, input logic [255:0] pat, input bit coincide);
        d_frame = 1'b1;
        d_clk   = 1'b0;
        tick(4);
        for (int i = 0; i < n; i++) begin
            d_data = pat[i % 256];
            tick(2);
            d_clk = 1'b1;
            if (coincide && i == n - 1) d_frame = 1'b0;
            tick(2);
            d_clk = 1'b0;
        end
        tick(4);
        d_frame = 1'b0;
        tick(6);
    endtask

    logic [255:0] v1, v3, v4, v5, p55, pAA;
    int t0, s_av, s_ae, s_bv, s_be, s_cv, s_ce, s_cr, g;
    logic seen;

    initial begin
        v1  = (256'd1 << 255) | 256'd1;
        p55 = {64{4'h5}};
        pAA = {64{4'hA}};
        v3  = {8{32'hC0FFEE11}};
        v4  = {32{8'h96}};
        v5  = {4{64'h0123_4567_89AB_CDEF}};
        rst_a = 1'b1; rst_b = 1'b1;
        a_start = 1'b0; a_ready = 1'b0; a_send = '0;
        sel_direct = 1'b0; d_clk = 1'b0; d_data = 1'b0; d_frame = 1'b0;
        c_start = 1'b0; c_send = '0;
        tick(3);
        chk("rst_txBusy",   256'(a_busy),   '0);
        chk("rst_txDone",   256'(a_done),   '0);
        chk("rst_clkOut",   256'(a_clko),   '0);
        chk("rst_dataOut",  256'(a_datao),  '0);
        chk("rst_frameOut", 256'(a_frameo), '0);
        chk("rst_rxValid",  256'(a_rxv),    '0);
        chk("rst_rxError",  256'(a_rxe),    '0);
        chk("rst_ready",    256'(a_rdy),    256'(1));
        chk("rst_rbuf",     a_rbuf,         '0);
        rst_a = 1'b0; rst_b = 1'b0;
        tick(2);

        // start without readyForSend must never launch a frame
        a_start = 1'b1;
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            seen = seen | a_frameo | a_clko | a_busy;
        end
        chk("noready_idle", 256'(seen), '0);
        a_start = 1'b0;

        // single loopback frame, payload change and extra start mid-frame ignored
        s_av = a_nv; s_ae = a_ne; s_bv = b_nv;
        a_send = v1; a_ready = 1'b1; a_start = 1'b1; t0 = cyc;
        @(negedge clk);
        a_start = 1'b0;
        chk("t1_busy",  256'(a_busy),   256'(1));
        chk("t1_frame", 256'(a_frameo), 256'(1));
        chk("t1_bit0",  256'(a_datao),  256'(1));
        a_send = '1;
        tick(99);
        chk("t1_rx_busy", 256'(a_rdy), '0);
        tick(400);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        wait_done(1'b0);
        chk("t1_latency", 256'(cyc - t0), 256'(2049));
        chk("t1_done_lines", 256'({a_busy, a_frameo, a_clko, a_datao}), '0);
        tick(9);
        chk("t1_no_restart", 256'({a_busy, a_frameo, a_done}), '0);
        chk("t1_a_nvalid", 256'(a_nv - s_av), 256'(1));
        chk("t1_a_nerr",   256'(a_ne - s_ae), '0);
        chk("t1_a_rbuf",   a_rbuf, v1);
        chk("t1_b_nvalid", 256'(b_nv - s_bv), 256'(1));
        chk("t1_b_rbuf",   b_rbuf, v1);
        chk("t1_a_ready",  256'(a_rdy), 256'(1));
        chk("b_tx_idle", 256'({b_busy, b_done, b_clko, b_datao, b_frameo}), '0);

        // back-to-back frames with start held high
        s_av = a_nv; s_ae = a_ne;
        a_send = p55; a_start = 1'b1;
        @(negedge clk);
        wait_done(1'b0);
        a_send = pAA;
        g = 0;
        while (!a_frameo && g < 10) begin
            @(negedge clk);
            g++;
        end
        a_start = 1'b0;
        chk("t2_gap", 256'(g), 256'(2));
        tick(6);
        chk("t2_rbuf1",   a_rbuf, p55);
        chk("t2_nvalid1", 256'(a_nv - s_av), 256'(1));
        wait_done(1'b0);
        tick(8);
        chk("t2_rbuf2",   a_rbuf, pAA);
        chk("t2_nvalid2", 256'(a_nv - s_av), 256'(2));
        chk("t2_nerr",    256'(a_ne - s_ae), '0);
        chk("t2_b_rbuf",  b_rbuf, pAA);

        // reset of A 1200 clk into a frame; B sees a short frame
        s_bv = b_nv; s_be = b_ne;
        a_send = v3; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        tick(1199);
        rst_a = 1'b1;
        @(negedge clk);
        chk("t3_rst_frame", 256'(a_frameo), '0);
        chk("t3_rst_lines", 256'({a_busy, a_clko, a_datao, a_done}), '0);
        chk("t3_rst_ready", 256'(a_rdy), 256'(1));
        chk("t3_rst_rbuf",  a_rbuf, '0);
        tick(2);
        rst_a = 1'b0;
        tick(10);
        chk("t3_b_err",   256'(b_ne - s_be), 256'(1));
        chk("t3_b_valid", 256'(b_nv - s_bv), '0);
        chk("t3_b_keep",  b_rbuf, pAA);
        s_av = a_nv; s_bv = b_nv;
        a_send = v4; a_start = 1'b1; t0 = cyc;
        @(negedge clk);
        a_start = 1'b0;
        wait_done(1'b0);
        chk("t3_latency", 256'(cyc - t0), 256'(2049));
        tick(8);
        chk("t3_b_recover", b_rbuf, v4);
        chk("t3_b_nvalid",  256'(b_nv - s_bv), 256'(1));
        chk("t3_a_rbuf",    a_rbuf, v4);
        chk("t3_a_nvalid",  256'(a_nv - s_av), 256'(1));

        // directly driven frames: short, long, exact, exact with coincident last edge
        sel_direct = 1'b1;
        tick(2);
        s_av = a_nv; s_ae = a_ne;
        drive_frame(255, v5, 1'b0);
        chk("t4_short_err", 256'(a_ne - s_ae), 256'(1));
        drive_frame(259, v5, 1'b0);
        chk("t4_long_err", 256'(a_ne - s_ae), 256'(2));
        chk("t4_no_valid", 256'(a_nv - s_av), '0);
        chk("t4_keep",     a_rbuf, v4);
        drive_frame(256, v5, 1'b0);
        chk("t4_exact_valid", 256'(a_nv - s_av), 256'(1));
        chk("t4_exact_rbuf",  a_rbuf, v5);
        drive_frame(256, ~v5, 1'b1);
        chk("t4_coinc_valid", 256'(a_nv - s_av), 256'(2));
        chk("t4_coinc_rbuf",  a_rbuf, ~v5);
        chk("t4_total_err",   256'(a_ne - s_ae), 256'(2));
        sel_direct = 1'b0;

        // small geometry: DATA_W=8, four clk per bit
        s_cv = c_nv; s_ce = c_ne; s_cr = c_rise;
        c_send = 8'hC3; c_start = 1'b1; t0 = cyc;
        @(negedge clk);
        c_start = 1'b0;
        chk("c_busy", 256'(c_busy), 256'(1));
        wait_done(1'b1);
        chk("c_latency", 256'(cyc - t0), 256'(33));
        tick(6);
        chk("c_clk_rises", 256'(c_rise - s_cr), 256'(8));
        chk("c_nvalid",    256'(c_nv - s_cv), 256'(1));
        chk("c_nerr",      256'(c_ne - s_ce), '0);
        chk("c_rbuf",      256'(c_rbuf), 256'(8'hC3));
        chk("c_ready",     256'(c_rdy), 256'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
